hilo_muldiv: RTL and testbench

//  HI/LO architectural register pair plus iterative multiply/divide engine.

---
 rtl/hilo_muldiv.sv | 156 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO architectural register pair with an iterative radix-2 multiply/divide engine.
// One shift-add or restoring shift-subtract step per cycle; result lands in HI/LO 33 cycles after issue.
module hilo_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_hilo_en,
    input  logic [DATA_WIDTH-1:0] wb_hi_data,
    input  logic [DATA_WIDTH-1:0] wb_lo_data,
    input  logic                  md_start,
    input  logic [1:0]            md_op,
    input  logic [DATA_WIDTH-1:0] md_operand_1,
    input  logic [DATA_WIDTH-1:0] md_operand_2,
    input  logic                  md_cancel,
    output logic                  md_busy,
    output logic                  md_done,
    output logic                  stall_req,
    output logic [DATA_WIDTH-1:0] hi_val,
    output logic [DATA_WIDTH-1:0] lo_val,
    output logic                  md_state
);

    localparam int W = DATA_WIDTH;

    // Handshake: EX holds md_start (level) together with op/operands while stall_req is high.
    // The instruction is consumed on the edge where md_done is sampled high; a flush is
    // signalled by md_cancel, which aborts RUN and blocks a new start in IDLE.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 is_div_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic                 div_zero_q;
    logic [W-1:0]         raw_a_q;
    logic [W-1:0]         m_q;       // multiplicand (mul) or divisor (div) magnitude
    logic [2*W-1:0]       p_q;       // {acc/remainder, multiplier/quotient}

    logic                 is_signed;
    logic [W-1:0]         abs_1;
    logic [W-1:0]         abs_2;
    logic [2*W-1:0]       p_next;
    logic [W:0]           mul_sum;
    logic [W:0]           div_t;
    logic [W+1:0]         div_diff;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         quo;
    logic [W-1:0]         rem;
    logic [W-1:0]         res_hi;
    logic [W-1:0]         res_lo;

    assign is_signed = ~md_op[0];
    assign abs_1     = (is_signed && md_operand_1[W-1]) ? -md_operand_1 : md_operand_1;
    assign abs_2     = (is_signed && md_operand_2[W-1]) ? -md_operand_2 : md_operand_2;

    assign md_busy   = (state == RUN);
    assign md_state  = state;
    assign stall_req = md_busy | (md_start & ~md_done);

    always_comb begin
        mul_sum  = '0;
        div_t    = '0;
        div_diff = '0;
        p_next   = p_q;
        if (is_div_q) begin
            div_t    = {p_q[2*W-1:W], p_q[W-1]};
            div_diff = {1'b0, div_t} - {2'b00, m_q};
            if (!div_diff[W+1]) begin
                p_next = {div_diff[W-1:0], p_q[W-2:0], 1'b1};
            end else begin
                p_next = {div_t[W-1:0], p_q[W-2:0], 1'b0};
            end
        end else begin
            mul_sum = p_q[0] ? ({1'b0, p_q[2*W-1:W]} + {1'b0, m_q}) : {1'b0, p_q[2*W-1:W]};
            p_next  = {mul_sum, p_q[W-1:1]};
        end
    end

    always_comb begin
        prod   = neg_res_q ? -p_q : p_q;
        quo    = neg_res_q ? -p_q[W-1:0] : p_q[W-1:0];
        rem    = neg_rem_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = raw_a_q;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            md_done    <= 1'b0;
            hi_val     <= '0;
            lo_val     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            raw_a_q    <= '0;
            m_q        <= '0;
            p_q        <= '0;
        end else begin
            md_done <= 1'b0;
            if (wb_hilo_en) begin
                hi_val <= wb_hi_data;
                lo_val <= wb_lo_data;
            end
            case (state)
                IDLE: begin
                    if (!md_cancel && md_start && !md_done) begin
                        state      <= RUN;
                        cnt        <= '0;
                        is_div_q   <= md_op[1];
                        neg_res_q  <= is_signed & (md_operand_1[W-1] ^ md_operand_2[W-1]);
                        neg_rem_q  <= is_signed & md_op[1] & md_operand_1[W-1];
                        div_zero_q <= (md_operand_2 == '0);
                        raw_a_q    <= md_operand_1;
                        m_q        <= md_op[1] ? abs_2 : abs_1;
                        p_q        <= {{W{1'b0}}, (md_op[1] ? abs_1 : abs_2)};
                    end
                end
                RUN: begin
                    if (md_cancel) begin
                        state <= IDLE;
                    end else if (cnt == CNT_WIDTH'(DATA_WIDTH)) begin
                        // Engine result overrides a coincident write-back.
                        hi_val  <= res_hi;
                        lo_val  <= res_lo;
                        md_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        p_q <= p_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus randomized ops,
// expected HI/LO pushed to a queue at issue and checked by a monitor on md_done.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_hilo_en;
    logic [31:0] wb_hi_data;
    logic [31:0] wb_lo_data;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_operand_1;
    logic [31:0] md_operand_2;
    logic        md_cancel;
    logic        md_busy;
    logic        md_done;
    logic        stall_req;
    logic [31:0] hi_val;
    logic [31:0] lo_val;
    logic        md_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    hilo_muldiv #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .wb_hilo_en(wb_hilo_en), .wb_hi_data(wb_hi_data), .wb_lo_data(wb_lo_data),
        .md_start(md_start), .md_op(md_op),
        .md_operand_1(md_operand_1), .md_operand_2(md_operand_2),
        .md_cancel(md_cancel), .md_busy(md_busy), .md_done(md_done),
        .stall_req(stall_req), .hi_val(hi_val), .lo_val(lo_val), .md_state(md_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {32'((ua % ub)), 32'((ua / ub))};
                end
            end
        endcase
        return res;
    endfunction

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && md_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                chk("hilo_result", {hi_val, lo_val}, exp_q.pop_front());
            end
        end
    end

    // Issue one op; wb_at = k > 0 writes AAAAAAAA/wb pattern at the k-th cycle after issue.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int wb_at);
        int  stall_cnt;
        bit  done_seen;
        @(negedge clk);
        md_start = 1'b1;
        md_op = op;
        md_operand_1 = a;
        md_operand_2 = b;
        exp_q.push_back(exp);
        #1;
        stall_cnt = stall_req ? 1 : 0;
        done_seen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            wb_hilo_en = 1'b0;
            md_operand_1 = $urandom;
            md_operand_2 = $urandom;
            if (md_done) begin
                done_seen = 1'b1;
                break;
            end
            if (stall_req) stall_cnt++;
            if (k == wb_at) begin
                wb_hilo_en = 1'b1;
                wb_hi_data = 32'hAAAA_AAAA;
                wb_lo_data = 32'hAAAA_AAAA;
            end
        end
        chk("done_seen", 64'(done_seen), 64'd1);
        chk("stall_cycles", 64'(stall_cnt), 64'd34);
        chk("stall_low_at_done", 64'(stall_req), 64'd0);
        // md_start is still held across the edge where md_done is high: must not restart.
        @(negedge clk);
        md_start = 1'b0;
        chk("no_restart", 64'(md_busy), 64'd0);
    endtask

    initial begin
        logic [63:0] saved;
        logic [31:0] a, b;
        logic [1:0]  op;
        int          dones;

        rst = 1'b1;
        wb_hilo_en = 1'b0;
        wb_hi_data = '0;
        wb_lo_data = '0;
        md_start = 1'b0;
        md_op = '0;
        md_operand_1 = '0;
        md_operand_2 = '0;
        md_cancel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hilo", {hi_val, lo_val}, 64'h0);
        chk("rst_busy_done_stall", {61'h0, md_busy, md_done, stall_req}, 64'h0);
        chk("rst_state", 64'(md_state), 64'd0);
        md_start = 1'b1;
        #1;
        chk("rst_stall_follows_start", 64'(stall_req), 64'd1);
        md_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Write-back path
        @(negedge clk);
        wb_hilo_en = 1'b1;
        wb_hi_data = 32'h1234_5678;
        wb_lo_data = 32'h9ABC_DEF0;
        @(negedge clk);
        wb_hilo_en = 1'b0;
        chk("wb_hilo", {hi_val, lo_val}, 64'h1234_5678_9ABC_DEF0);
        chk("wb_idle", 64'(md_busy), 64'd0);

        // Directed results
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0);

        // Write-back colliding with engine completion: engine wins
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 33);

        // Cancel mid-run
        saved = {hi_val, lo_val};
        dones = 0;
        @(negedge clk);
        md_start = 1'b1;
        md_op = 2'b01;
        md_operand_1 = 32'hFFFF_FFFF;
        md_operand_2 = 32'hFFFF_FFFF;
        repeat (11) @(negedge clk);
        md_cancel = 1'b1;
        md_start = 1'b0;
        @(negedge clk);
        md_cancel = 1'b0;
        chk("cancel_busy_low", 64'(md_busy), 64'd0);
        chk("cancel_hilo_kept", {hi_val, lo_val}, saved);
        repeat (40) begin
            @(negedge clk);
            if (md_done) dones++;
        end
        chk("cancel_no_done", 64'(dones), 64'd0);

        // Reset mid-run
        @(negedge clk);
        md_start = 1'b1;
        md_op = 2'b11;
        md_operand_1 = 32'hDEAD_BEEF;
        md_operand_2 = 32'h0000_0013;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        md_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hilo", {hi_val, lo_val}, 64'h0);
        chk("midrst_busy_done", {62'h0, md_busy, md_done}, 64'h0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'($urandom_range(0, 100));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 50));
                3: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(op, a, b, ref_md(op, a, b), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
